reg_serial_tx: RTL



---
 rtl/reg_serial_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_serial_tx.sv
// Serial transmitter for the data register readback path.
// Frame: start bit (0), width data bits MSB-first, stop bit (1); the line idles high.
// The parallel value is snapshotted when a request is accepted. Requests made while a
// frame is in flight are dropped.
module reg_serial_tx #(
  parameter int unsigned width        = 12,
  parameter int unsigned clks_per_bit = 434
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] data,
  input  logic             start,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(clks_per_bit);
  localparam int unsigned BitW = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [width-1:0]  shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_last;
  logic              bit_last;
  logic [width-1:0]  shifted;

  assign cnt_last = (cycle_cnt_q == CntW'(clks_per_bit - 1));
  assign bit_last = (bit_cnt_q == BitW'(width - 1));
  assign shifted  = shift_q << 1;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d     = data;
          state_d     = StStart;
          cycle_cnt_d = '0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
        end
      end
      StStart: begin
        if (cnt_last) begin
          state_d     = StData;
          bit_cnt_d   = '0;
          cycle_cnt_d = '0;
          tx_d        = shift_q[width-1];
        end else begin
          cycle_cnt_d = cycle_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_last) begin
          cycle_cnt_d = '0;
          if (bit_last) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            // Drop the bit just sent and present the next MSB.
            shift_d   = shifted;
            tx_d      = shifted[width-1];
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_last) begin
          state_d     = StIdle;
          cycle_cnt_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          cycle_cnt_d = cycle_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
